csa_accumulator: RTL and testbench

Parametrised multi-operand carry-save accumulator for the weight-stationary systolic array output path. Each accepted beat of NUM_IN signed partial products is compressed with a redundant (sum, carry) accumulator through a combinational 3:2 compressor tree, so no carry propagates during accumulation. On the last beat of a group, a single carry-propagate addition resolves the pair into a binary result. The result is presented on a valid/ready output port.

---
 rtl/csa_accumulator.sv | 106 ++++++++++
 tb/tb_csa_accumulator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save multi-operand group accumulator with one final carry-propagate add.
// Optional output clamping when CSA_ACC_SATURATE_EN is defined (default: two's-complement wrap).
module csa_accumulator #(
    parameter int WIDTH     = 4,
    parameter int NUM_IN    = 4,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [CNT_WIDTH-1:0]    out_beats
);

    typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] sum_q, carry_q, sum_d, carry_d, op, cy;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [OUT_WIDTH-1:0] narrow;

    // Chain of 3:2 compressors folding each operand into the redundant pair.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        op      = '0;
        cy      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            op      = ACC_WIDTH'($signed(in_data[k*WIDTH +: WIDTH]));
            cy      = ((sum_d & carry_d) | (sum_d & op) | (carry_d & op)) << 1;
            sum_d   = sum_d ^ carry_d ^ op;
            carry_d = cy;
        end
    end

`ifdef CSA_ACC_SATURATE_EN
    logic [ACC_WIDTH-1:0]           result;
    logic [ACC_WIDTH-OUT_WIDTH:0]   upper;
    logic [OUT_WIDTH-1:0]           min_val;
    always_comb begin
        result  = sum_q + carry_q;
        upper   = result[ACC_WIDTH-1:OUT_WIDTH-1];
        min_val = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
        narrow  = (&upper || ~|upper) ? result[OUT_WIDTH-1:0]
                : (result[ACC_WIDTH-1] ? min_val : ~min_val);
    end
`else
    assign narrow = OUT_WIDTH'(sum_q + carry_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
        end else if (clr) begin
            state     <= ACC;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: if (in_valid) begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_WIDTH'(~&cnt_q);
                    if (in_last) begin
                        state    <= RESOLVE;
                        in_ready <= 1'b0;
                    end
                end
                RESOLVE: begin
                    out_data  <= narrow;
                    out_beats <= cnt_q;
                    sum_q     <= '0;
                    carry_q   <= '0;
                    cnt_q     <= '0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: randomized self-checking bench for csa_accumulator against an integer-sum model.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid;
    logic [7:0]  out_data, out_beats;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  last_exp;

    csa_accumulator dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    // Group sum reduced modulo 2^16, then clamped or wrapped to 8 bits.
    function automatic logic [7:0] model_out(input longint total);
        longint a;
        a = ((total % 65536) + 65536) % 65536;
        if (a >= 32768) a -= 65536;
`ifdef CSA_ACC_SATURATE_EN
        if (a > 127) a = 127;
        if (a < -128) a = -128;
`endif
        return 8'(a);
    endfunction

    function automatic logic [7:0] model_beats(input int nb);
        return 8'((nb > 255) ? 255 : nb);
    endfunction

    task automatic send(input int nb, input logic [15:0] pat, input bit rnd, input bit last,
                        output longint total);
        logic [15:0] d;
        total = 0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            d        = rnd ? 16'($urandom) : pat;
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last && (i == nb - 1);
            for (int k = 0; k < 4; k++) total += longint'($signed(d[k*4 +: 4]));
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, out_data, out_beats} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b vld=%b data=%h beats=%0d want 1 0 00 0", in_ready, out_valid, out_data, out_beats);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        longint t;
        out_ready = 1'b1;
        send(1, 16'hC321, 1'b0, 1'b1, t);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resolve: got vld=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        last_exp = model_out(t);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== last_exp || out_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL single_result: got vld=%b data=%h beats=%0d want 1 %h 1", out_valid, out_data, out_beats, last_exp);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_handshake: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_burst();
        longint t = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_ready beat %0d: got %b want 1", i, in_ready);
            end
            in_valid = 1'b1; in_data = 16'h7777; in_last = (i == 2); t += 28;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        last_exp = model_out(t);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== last_exp || out_beats !== 8'd3) begin
            n_fail++;
            $display("FAIL burst_result: got vld=%b data=%h beats=%0d want 1 %h 3", out_valid, out_data, out_beats, last_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        longint t;
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            send(s == 2 ? 300 : 10, s == 0 ? 16'h7777 : s == 1 ? 16'h8888 : 16'h1111, 1'b0, 1'b1, t);
            @(negedge clk);
            last_exp = model_out(t);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== last_exp || out_beats !== model_beats(s == 2 ? 300 : 10)) begin
                n_fail++;
                $display("FAIL overflow case %0d: got vld=%b data=%h beats=%0d want 1 %h %0d", s, out_valid, out_data, out_beats, last_exp, model_beats(s == 2 ? 300 : 10));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        longint t;
        int nb;
        out_ready = 1'b1;
        for (int g = 0; g < 15; g++) begin
            nb = $urandom_range(1, 12);
            send(nb, '0, 1'b1, 1'b1, t);
            @(negedge clk);
            last_exp = model_out(t);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== last_exp || out_beats !== model_beats(nb)) begin
                n_fail++;
                $display("FAIL random group %0d: got vld=%b data=%h beats=%0d want 1 %h %0d", g, out_valid, out_data, out_beats, last_exp, nb);
            end
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random handshake %0d: got rdy=%b vld=%b want 1 0", g, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        longint t;
        out_ready = 1'b0;
        send(2, '0, 1'b1, 1'b1, t);
        last_exp = model_out(t);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== last_exp || out_beats !== 8'd2 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got vld=%b data=%h beats=%0d rdy=%b want 1 %h 2 0", c, out_valid, out_data, out_beats, in_ready, last_exp);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_clr();
        longint t;
        out_ready = 1'b1;
        send(2, 16'h5555, 1'b0, 1'b0, t);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== last_exp) begin
            n_fail++;
            $display("FAIL clr_state: got rdy=%b vld=%b data=%h want 1 0 %h", in_ready, out_valid, out_data, last_exp);
        end
        send(1, 16'h1111, 1'b0, 1'b1, t);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd4 || out_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL clr_result: got vld=%b data=%h beats=%0d want 1 04 1", out_valid, out_data, out_beats);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        longint t;
        send(2, '0, 1'b1, 1'b0, t);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_data, out_beats} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_group: got rdy=%b vld=%b data=%h beats=%0d want 1 0 00 0", in_ready, out_valid, out_data, out_beats);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        send(3, 16'h3333, 1'b0, 1'b1, t);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_data, out_beats} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_in_out: got rdy=%b vld=%b data=%h beats=%0d want 1 0 00 0", in_ready, out_valid, out_data, out_beats);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(1, 16'h2222, 1'b0, 1'b1, t);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd8 || out_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_recover: got vld=%b data=%h beats=%0d want 1 08 1", out_valid, out_data, out_beats);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_random();
        test_backpressure();
        test_clr();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
